fp32_divider: RTL and testbench
===============================

# fp32_divider

Sequential IEEE-754 binary32 divider; the quotient-side counterpart of the FP32 multiplier datapath. It accepts a dividend/divisor pair over a valid/ready handshake and forms the sign by XOR. It performs a radix-2 restoring mantissa division, normalizes, rounds and packs the result, then returns the result and exception flags over a second valid/ready handshake. One operation is in flight at a time.

## Interface
- No parameters; format fixed at binary32 (1/8/23).
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block idle, can accept; low while rst high
- a  in  32  dividend, binary32
- b  in  32  divisor, binary32
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  quotient, binary32
- flags  out  4  {invalid, div_by_zero, overflow, underflow}

## Operation
- States: IDLE, DIV, NORM, DONE. Reset → IDLE; out_valid=0, result=0, flags=0.
- in_ready = (state==IDLE) && !rst. Accept on in_valid && in_ready. a and b are sampled only at accept.
- Unpack at accept: sign = a[31]^b[31]. Exponent-0 inputs (zero/denormal) are flushed to signed zero.
- Special cases resolve at accept and go IDLE→DONE:
  - either NaN → 0x7FC00000, invalid
  - 0/0 or inf/inf → 0x7FC00000, invalid
  - finite nonzero/0 → ±inf, div_by_zero
  - inf/finite → ±inf, no flag
  - 0/nonzero or finite/inf → ±0, no flag
- Normal path: exp = ea − eb + 127, held as a 10-bit signed value. ma and mb are 24-bit with the hidden 1. rem ← ma (25-bit), counter ← 25.
- DIV, one quotient bit per cycle, 26 cycles:
  - q bit = (rem ≥ mb); if set, rem −= mb
  - rem <<= 1
  - q shifts in at LSB
  - exit to NORM when counter==0
- NORM, single cycle:
  - q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem≠0)
  - q[25]=0: mant=q[24:1], guard=q[0], sticky=(rem≠0), exp−=1
  - round (see Configuration); mantissa carry-out → mant=0x800000, exp+=1
  - exp ≥ 255 → ±inf (0x7F800000|sign), overflow
  - exp ≤ 0 → ±0, underflow
- DONE: out_valid=1; result and flags are held stable until out_ready. DONE→IDLE on out_ready. No new accept in the same cycle.
- Reset mid-operation aborts the operation; no out_valid is produced for it.

## Timing
- Normal operands: out_valid rises 28 cycles after the accept edge (26 DIV + 1 NORM + DONE register).
- Special cases: out_valid rises 1 cycle after the accept edge.
- Minimum issue interval: latency + 1 (IDLE cycle after handoff).
- out_ready held low: result and flags are unchanged, in_ready stays 0.
- in_ready returns 1 on the first cycle after rst deasserts.

## Configuration
- FP32_DIV_ROUND_EN defined: round-to-nearest-even, increment when guard && (sticky || mant[0]).
- Not defined: round toward zero (truncate; guard and sticky are ignored).
- Latency is identical either way.

## Structure
- Shared package fp32_pkg holds:
  - EXP_W=8, MAN_W=23, BIAS=127, QNAN=32'h7FC00000, INF constant
  - unpacked-operand struct {sign, exp, man}
  - state enum
  - flag bit indices
- One sub-module, fp32_div_round: combinational normalize/round/pack used in NORM. The FSM, counter and remainder datapath stay in fp32_divider.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB with FP32_DIV_ROUND_EN; 0x3EAAAAAA without.
- 0xBF800000 / 0x00000000 → 0xFF800000, div_by_zero, latency 1.
- 0/0 and 0x7FC00001 / 0x3F800000 → 0x7FC00000, invalid.
- 0x7F000000 / 0x3E800000 → 0x7F800000, overflow. 0x00800000 / 0x40000000 → 0x00000000, underflow.
- out_ready low 5 cycles in DONE → result stable, in_ready 0. rst pulsed at DIV cycle 10 → no out_valid, in_ready 1 the cycle after rst falls.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand view, divider states and flag positions.
// Rounding mode is selected by FP32_DIV_ROUND_EN (defined: nearest-even, else truncate).
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] INF  = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int FLAG_INVALID     = 3;
    localparam int FLAG_DIV_BY_ZERO = 2;
    localparam int FLAG_OVERFLOW    = 1;
    localparam int FLAG_UNDERFLOW   = 0;

endpackage

// File: rtl/fp32_div_round.sv
// Combinational normalize/round/pack stage for the raw divider quotient.
// FP32_DIV_ROUND_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module fp32_div_round
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [25:0]       quo,
    input  logic              rem_nz,
    output logic [31:0]       result,
    output logic [3:0]        flags
);

    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic signed [9:0] exp_adj;
    logic              round_up;
    logic [24:0]       sum;
    logic signed [9:0] exp_r;
    logic              unused_bits;

    // A quotient below 1.0 needs one extra bit of left shift and one less exponent.
    always_comb begin
        mant    = quo[25:2];
        guard   = quo[1];
        sticky  = quo[0] | rem_nz;
        exp_adj = exp_in;
        if (!quo[25]) begin
            mant    = quo[24:1];
            guard   = quo[0];
            sticky  = rem_nz;
            exp_adj = exp_in - 10'sd1;
        end
    end

`ifdef FP32_DIV_ROUND_EN
    assign round_up    = guard && (sticky || mant[0]);
    assign unused_bits = sum[23];
`else
    assign round_up    = 1'b0;
    assign unused_bits = ^{sum[23], guard, sticky};
`endif

    assign sum = {1'b0, mant} + {24'd0, round_up};

    // A carry out of the mantissa leaves the fraction at zero and bumps the exponent.
    always_comb begin
        exp_r  = exp_adj + {9'd0, sum[24]};
        result = {sign, exp_r[7:0], sum[22:0]};
        flags  = '0;
        if (exp_r >= 10'sd255) begin
            result                = INF | {sign, 31'd0};
            flags[FLAG_OVERFLOW]  = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result                = {sign, 31'd0};
            flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential binary32 divider: restoring radix-2 mantissa division, one op in flight.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; default build truncates.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    div_state_t        state, state_n;
    fp32_t             ua, ub;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic              sign;
    logic              accept;
    logic              spec_hit;
    logic [31:0]       spec_result;
    logic [3:0]        spec_flags;
    logic signed [9:0] exp_calc;

    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [24:0]       rem_q;
    logic [23:0]       mb_q;
    logic [25:0]       quo_q;
    logic [4:0]        cnt_q;
    logic [31:0]       result_q;
    logic [3:0]        flags_q;

    logic              q_bit;
    logic [24:0]       diff;
    logic [31:0]       rnd_result;
    logic [3:0]        rnd_flags;

    assign ua       = a;
    assign ub       = b;
    assign sign     = ua.sign ^ ub.sign;
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    assign a_zero = (ua.exp == 8'd0);
    assign b_zero = (ub.exp == 8'd0);
    assign a_inf  = (ua.exp == 8'hFF) && (ua.man == '0);
    assign b_inf  = (ub.exp == 8'hFF) && (ub.man == '0);
    assign a_nan  = (ua.exp == 8'hFF) && (ua.man != '0);
    assign b_nan  = (ub.exp == 8'hFF) && (ub.man != '0);

    assign exp_calc = {2'b00, ua.exp} - {2'b00, ub.exp} + 10'(BIAS);

    // Zero, infinity and NaN operands bypass the divider and finish straight from IDLE.
    always_comb begin
        spec_hit    = 1'b1;
        spec_result = {sign, 31'd0};
        spec_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result                = QNAN;
            spec_flags[FLAG_INVALID]   = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_result                  = INF | {sign, 31'd0};
            spec_flags[FLAG_DIV_BY_ZERO] = 1'b1;
        end else if (a_inf) begin
            spec_result = INF | {sign, 31'd0};
        end else if (a_zero || b_inf) begin
            spec_result = {sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = spec_hit ? DONE : DIV;
            DIV:  if (cnt_q == 5'd0) state_n = NORM;
            NORM: state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    assign q_bit = (rem_q >= {1'b0, mb_q});
    assign diff  = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            mb_q     <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign_q <= sign;
                    exp_q  <= exp_calc;
                    rem_q  <= {2'b01, ua.man};
                    mb_q   <= {1'b1, ub.man};
                    quo_q  <= '0;
                    cnt_q  <= 5'd25;
                    if (spec_hit) begin
                        result_q <= spec_result;
                        flags_q  <= spec_flags;
                    end
                end
                DIV: begin
                    rem_q <= diff << 1;
                    quo_q <= {quo_q[24:0], q_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                NORM: begin
                    result_q <= rnd_result;
                    flags_q  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    fp32_div_round u_round (
        .sign   (sign_q),
        .exp_in (exp_q),
        .quo    (quo_q),
        .rem_nz (rem_q != '0),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: directed corner cases plus random operands
// compared against an exact-arithmetic reference model (honours FP32_DIV_ROUND_EN).
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int total_count = 0;
    int bad_count   = 0;

    always #5 clk = ~clk;

    fp32_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Exact rational quotient via integer division; rounding decided from the remainder.
    function automatic void ref_model(input logic [31:0] av, input logic [31:0] bv,
                                      output logic [31:0] r, output logic [3:0] f);
        logic   s;
        int     ea, eb, e, be;
        longint ma, mb, mant, rest;
        bit     az, bz, ai, bi, an, bn;
        s  = av[31] ^ bv[31];
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (av[22:0] == 23'd0);
        bi = (eb == 255) && (bv[22:0] == 23'd0);
        an = (ea == 255) && (av[22:0] != 23'd0);
        bn = (eb == 255) && (bv[22:0] != 23'd0);
        f  = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (bz && !ai) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0100;
        end else if (ai) begin
            r = {s, 8'hFF, 23'd0};
        end else if (az || bi) begin
            r = {s, 31'd0};
        end else begin
            ma = longint'({1'b1, av[22:0]});
            mb = longint'({1'b1, bv[22:0]});
            e  = ea - eb;
            if (ma >= mb) begin
                mant = (ma << 23) / mb;
                rest = (ma << 23) % mb;
            end else begin
                mant = (ma << 24) / mb;
                rest = (ma << 24) % mb;
                e    = e - 1;
            end
`ifdef FP32_DIV_ROUND_EN
            if ((2 * rest > mb) || ((2 * rest == mb) && mant[0]))
                mant = mant + 1;
`endif
            if (mant == (longint'(1) << 24)) begin
                mant = longint'(1) << 23;
                e    = e + 1;
            end
            be = e + 127;
            if (be >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0010;
            end else if (be <= 0) begin
                r = {s, 31'd0};
                f = 4'b0001;
            end else begin
                r = {s, 8'(be), 23'(mant)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        int          k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        case (k)
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: v[30:23] = 8'h00;
            default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h7F;
        endcase
        return v;
    endfunction

    // Issues one operation, checks latency/result/flags, holds out_ready low for stall cycles.
    task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv, input int stall,
                                  output logic [31:0] res, output logic [3:0] flg);
        int          lat;
        int          waited;
        int          exp_lat;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("in_ready_idle", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_output("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ref_model(av, bv, exp_r, exp_f);
        exp_lat = (av[30:23] == 8'h00 || av[30:23] == 8'hFF ||
                   bv[30:23] == 8'h00 || bv[30:23] == 8'hFF) ? 1 : 28;
        check_output("latency", 32'(lat), 32'(exp_lat));
        check_output("result", result, exp_r);
        check_output("flags", 32'(flags), 32'(exp_f));
        res = result;
        flg = flags;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_output("stall_result", result, res);
            check_output("stall_flags", 32'(flags), 32'(flg));
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
            check_output("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("handoff_out_valid", 32'(out_valid), 32'd0);
        check_output("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic [31:0] av, bv;
        int          saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check_output("reset_in_ready", 32'(in_ready), 32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_result", result, 32'd0);
        check_output("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        #1;
        check_output("post_reset_in_ready", 32'(in_ready), 32'd1);

        apply_stimulus(32'h40C00000, 32'h40000000, 5, r, f);
        check_output("six_div_two", r, 32'h40400000);
        check_output("six_div_two_flags", 32'(f), 32'h0);

        apply_stimulus(32'h3F800000, 32'h40400000, 0, r, f);
`ifdef FP32_DIV_ROUND_EN
        check_output("one_third", r, 32'h3EAAAAAB);
`else
        check_output("one_third", r, 32'h3EAAAAAA);
`endif

        apply_stimulus(32'hBF800000, 32'h00000000, 1, r, f);
        check_output("neg_div_zero", r, 32'hFF800000);
        check_output("neg_div_zero_flags", 32'(f), 32'h4);

        apply_stimulus(32'h00000000, 32'h00000000, 0, r, f);
        check_output("zero_div_zero", r, 32'h7FC00000);
        check_output("zero_div_zero_flags", 32'(f), 32'h8);

        apply_stimulus(32'h7FC00001, 32'h3F800000, 0, r, f);
        check_output("nan_operand", r, 32'h7FC00000);
        check_output("nan_operand_flags", 32'(f), 32'h8);

        apply_stimulus(32'h7F000000, 32'h3E800000, 0, r, f);
        check_output("overflow", r, 32'h7F800000);
        check_output("overflow_flags", 32'(f), 32'h2);

        apply_stimulus(32'h00800000, 32'h40000000, 0, r, f);
        check_output("underflow", r, 32'h00000000);
        check_output("underflow_flags", 32'(f), 32'h1);

        // Abort a division part-way through with a one-cycle reset pulse.
        @(negedge clk);
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("abort_in_ready_after", 32'(in_ready), 32'd1);
        saw_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        check_output("abort_no_out_valid", 32'(saw_valid), 32'd0);
        check_output("abort_result_cleared", result, 32'd0);

        for (int i = 0; i < 40; i++) begin
            av = rand_operand();
            bv = rand_operand();
            apply_stimulus(av, bv, $urandom_range(0, 2), r, f);
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
